systolic_mac_array: RTL and testbench
=====================================

# systolic_mac_array

Output-stationary ROWS×COLUMNS systolic matrix-multiply engine. It generalises the single-step outer-product array into a K-beat streaming multiply-accumulate: C = A·B, one column of A and one row of B per beat. Input skewing is internal, the accumulators are wide, and ready/valid handshakes sit on both the input and the result side. It sits between the operand streamer and the result writer in the compute datapath.

## Interface
- ROWS, 2, PE rows (A column length)
- COLUMNS, 2, PE columns (B row length)
- WIDTH, 8, unsigned operand width
- ACC_WIDTH, 2*WIDTH+4, unsigned accumulator/result width
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_last  in  1  marks final beat (k = K-1) of a multiply
- a  in  ROWS*WIDTH  A column k; element i at [i*WIDTH +: WIDTH]
- b  in  COLUMNS*WIDTH  B row k; element j at [j*WIDTH +: WIDTH]
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid & out_ready
- c  out  ROWS*COLUMNS*ACC_WIDTH  C(i,j) at [(i*COLUMNS+j)*ACC_WIDTH +: ACC_WIDTH]
- busy  out  1  high in LOAD, DRAIN, DONE

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE→LOAD on accepted beat with in_last=0.
  - IDLE→DRAIN on accepted beat with in_last=1.
  - LOAD→DRAIN on accepted beat with in_last=1.
  - DRAIN→DONE when the drain counter expires.
  - DONE→IDLE on out_valid & out_ready.
- in_ready = 1 in IDLE and LOAD, 0 in DRAIN and DONE. out_valid = 1 only in DONE.
- Skew: row i operand delayed i cycles, column j operand delayed j cycles, via internal shift registers.
- Each PE registers its a operand and passes it right, registers its b operand and passes it down, and adds a*b to its accumulator.
- A cycle with no accepted beat (bubble, in LOAD or DRAIN) injects zero operands, so bubbles do not change the result.
- Arithmetic is unsigned. The product is 2*WIDTH bits, zero-extended to ACC_WIDTH. Accumulate overflow behaviour is set by Configuration.
- Accumulators clear to 0 on reset and on the DONE→IDLE handshake edge. c is driven directly from the accumulators and is held stable throughout DONE.
- K is unbounded; a single-beat multiply (K=1) is legal.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 after it; out_valid=0; busy=0; c=0; state=IDLE; skew and PE pipelines zeroed.
- Call the edge that accepts the in_last beat edge 0. out_valid rises after edge ROWS+COLUMNS, i.e. DRAIN lasts ROWS+COLUMNS cycles. Example: 2×2 gives out_valid 4 cycles after the last accept.
- Next-multiply throughput: the first beat of the next multiply is accepted no earlier than the cycle after the output handshake.
- out_ready may be high before out_valid; the handshake completes on the first edge where both are high.
- in_valid while in_ready=0 is ignored: no accept and no state change. The producer holds the beat.
- Reset asserted in any state, including mid-DRAIN or in DONE, aborts the operation, discards in-flight data and returns to reset values on that edge.

## Configuration
- SYSTOLIC_SATURATE_EN defined: each accumulator saturates at 2^ACC_WIDTH-1 and stays there until cleared.
- Undefined: each accumulator wraps modulo 2^ACC_WIDTH.
- The port list is identical in both builds.

## Structure
- Package systolic_pkg holds:
  - the state enum typedef (IDLE/LOAD/DRAIN/DONE);
  - the default-width constants;
  - the drain-count width function, clog2(ROWS+COLUMNS+1).
- Sub-module systolic_pe holds one PE: operand registers, multiplier, accumulator and the saturate/wrap logic. The top level contains the skew registers, the FSM, the drain counter and the generate grid.

## Test plan
- Default 2×2 multiply, two beats: beat 0 a=(1,3), b=(5,6); beat 1 a=(2,4), b=(7,8) with in_last. Required: C=(19,22,43,50), with out_valid exactly 4 cycles after the last accept.
- Same operands with 3 bubble cycles between beats and in_valid toggling. Required: identical C and identical latency measured from the last accept.
- Backpressure: out_ready held low for 5 cycles in DONE. Required: out_valid stays 1, c stays stable, in_ready stays 0, and a beat offered then is not accepted. Once out_ready rises, the next beat is accepted and the accumulators restart from 0 (K=1 with a=(2,2), b=(3,3) gives C=(6,6,6,6)).
- ACC_WIDTH=16, two beats with all operands 255. With SYSTOLIC_SATURATE_EN every C=65535; without it every C=64514.
- Reset pulsed during DRAIN of the first test. Required: out_valid never rises, c=0 and in_ready=1 the cycle after reset deasserts, and a following K=1 multiply with a=(1,1), b=(1,1) returns C=(1,1,1,1).
- ROWS=3, COLUMNS=2 parameterisation with identity-like operands. Required: correct C, with out_valid 5 cycles after the last accept.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the output-stationary systolic MAC array.
package systolic_pkg;

   localparam int unsigned DEF_ROWS      = 2;
   localparam int unsigned DEF_COLUMNS   = 2;
   localparam int unsigned DEF_WIDTH     = 8;
   localparam int unsigned DEF_ACC_WIDTH = 2 * DEF_WIDTH + 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Drain counter must hold values up to rows+cols.
   function automatic int unsigned drain_cnt_w(input int unsigned rows, input int unsigned cols);
      return $clog2(rows + cols + 1);
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards a right and b down, accumulates a*b.
// SYSTOLIC_SATURATE_EN selects saturating accumulation; otherwise wraps.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned ACC_WIDTH = 2 * WIDTH + 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clr_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic [WIDTH-1:0]     a_o,
   output logic [WIDTH-1:0]     b_o,
   output logic [ACC_WIDTH-1:0] acc_o
);

   localparam int unsigned PROD_W = 2 * WIDTH;
   localparam int unsigned SUM_W  = ACC_WIDTH + 1;

   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [ACC_WIDTH-1:0] acc_d;
   logic [PROD_W-1:0]    prod;

   assign prod = PROD_W'(a_i) * PROD_W'(b_i);

`ifdef SYSTOLIC_SATURATE_EN
   logic [SUM_W-1:0] sum;

   // Carry out of the accumulator pins it at all-ones until cleared.
   always_comb begin
      sum   = {1'b0, acc_q} + SUM_W'(prod);
      acc_d = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
   end
`else
   always_comb begin
      acc_d = acc_q + ACC_WIDTH'(prod);
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_i;
         b_q   <= b_i;
         acc_q <= clr_i ? '0 : acc_d;
      end
   end

   assign a_o   = a_q;
   assign b_o   = b_q;
   assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mac_array.sv
// ROWS x COLUMNS output-stationary systolic matrix multiplier with input skew and handshakes.
// SYSTOLIC_SATURATE_EN selects saturating accumulators (see systolic_pe).
module systolic_mac_array
   import systolic_pkg::*;
#(
   parameter int unsigned ROWS      = DEF_ROWS,
   parameter int unsigned COLUMNS   = DEF_COLUMNS,
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned ACC_WIDTH = 2 * WIDTH + 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_last,
   input  logic [ROWS*WIDTH-1:0]             a,
   input  logic [COLUMNS*WIDTH-1:0]          b,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [ROWS*COLUMNS*ACC_WIDTH-1:0] c,
   output logic                              busy
);

   localparam int unsigned CNT_W = drain_cnt_w(ROWS, COLUMNS);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;
   logic             fire;
   logic             clr;

   logic [WIDTH-1:0] a_h [ROWS][COLUMNS];
   logic [WIDTH-1:0] b_v [ROWS][COLUMNS];

   assign fire = in_valid & in_ready_q;
   assign clr  = out_valid_q & out_ready;

   // Control FSM; drain counter covers the skew plus grid traversal.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE, LOAD: begin
               in_ready_q <= 1'b1;
               if (fire) begin
                  busy_q <= 1'b1;
                  if (in_last) begin
                     state_q    <= DRAIN;
                     cnt_q      <= CNT_W'(ROWS + COLUMNS - 1);
                     in_ready_q <= 1'b0;
                  end else begin
                     state_q <= LOAD;
                  end
               end
            end
            DRAIN: begin
               if (cnt_q == '0) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

   // Row skew: row i sees its a operand i cycles late; bubbles inject zero.
   for (genvar i = 0; i < ROWS; i++) begin : g_askew
      if (i == 0) begin : g_direct
         assign a_h[0][0] = fire ? a[0 +: WIDTH] : '0;
      end else begin : g_delay
         logic [WIDTH-1:0] sr_q [i];
         always_ff @(posedge clock) begin
            if (reset) begin
               for (int d = 0; d < i; d++) sr_q[d] <= '0;
            end else begin
               sr_q[0] <= fire ? a[i*WIDTH +: WIDTH] : '0;
               for (int d = 1; d < i; d++) sr_q[d] <= sr_q[d-1];
            end
         end
         assign a_h[i][0] = sr_q[i-1];
      end
   end

   // Column skew: column j sees its b operand j cycles late.
   for (genvar j = 0; j < COLUMNS; j++) begin : g_bskew
      if (j == 0) begin : g_direct
         assign b_v[0][0] = fire ? b[0 +: WIDTH] : '0;
      end else begin : g_delay
         logic [WIDTH-1:0] sr_q [j];
         always_ff @(posedge clock) begin
            if (reset) begin
               for (int d = 0; d < j; d++) sr_q[d] <= '0;
            end else begin
               sr_q[0] <= fire ? b[j*WIDTH +: WIDTH] : '0;
               for (int d = 1; d < j; d++) sr_q[d] <= sr_q[d-1];
            end
         end
         assign b_v[0][j] = sr_q[j-1];
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLUMNS; j++) begin : g_col
         logic [WIDTH-1:0] a_nxt;
         logic [WIDTH-1:0] b_nxt;

         systolic_pe #(
            .WIDTH     (WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
         ) u_pe (
            .clock (clock),
            .reset (reset),
            .clr_i (clr),
            .a_i   (a_h[i][j]),
            .b_i   (b_v[i][j]),
            .a_o   (a_nxt),
            .b_o   (b_nxt),
            .acc_o (c[(i*COLUMNS+j)*ACC_WIDTH +: ACC_WIDTH])
         );

         // Edge PEs have nowhere to forward their operands.
         if (j + 1 < COLUMNS) begin : g_ar
            assign a_h[i][j+1] = a_nxt;
         end else begin : g_ae
            logic [WIDTH-1:0] a_unused;
            assign a_unused = a_nxt;
         end
         if (i + 1 < ROWS) begin : g_bd
            assign b_v[i+1][j] = b_nxt;
         end else begin : g_be
            logic [WIDTH-1:0] b_unused;
            assign b_unused = b_nxt;
         end
      end
   end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed, table-driven bench for systolic_mac_array (2x2, 2x2 with 16-bit acc, 3x2).
module tb_systolic_mac_array;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   // default 2x2, ACC_WIDTH 20
   logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        in_ready, out_valid, busy;
   logic [79:0] c;

   // 2x2, ACC_WIDTH 16
   logic        h_in_valid = 1'b0, h_in_last = 1'b0, h_out_ready = 1'b0;
   logic [15:0] h_a = '0, h_b = '0;
   logic        h_in_ready, h_out_valid, h_busy;
   logic [63:0] h_c;

   // 3x2, ACC_WIDTH 20
   logic         t_in_valid = 1'b0, t_in_last = 1'b0, t_out_ready = 1'b0;
   logic [23:0]  t_a = '0;
   logic [15:0]  t_b = '0;
   logic         t_in_ready, t_out_valid, t_busy;
   logic [119:0] t_c;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   systolic_mac_array dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .c(c), .busy(busy)
   );

   systolic_mac_array #(.ROWS(2), .COLUMNS(2), .WIDTH(8), .ACC_WIDTH(16)) dut_acc16 (
      .clock(clock), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
      .in_last(h_in_last), .a(h_a), .b(h_b), .out_valid(h_out_valid),
      .out_ready(h_out_ready), .c(h_c), .busy(h_busy)
   );

   systolic_mac_array #(.ROWS(3), .COLUMNS(2), .WIDTH(8), .ACC_WIDTH(20)) dut_r3 (
      .clock(clock), .reset(reset), .in_valid(t_in_valid), .in_ready(t_in_ready),
      .in_last(t_in_last), .a(t_a), .b(t_b), .out_valid(t_out_valid),
      .out_ready(t_out_ready), .c(t_c), .busy(t_busy)
   );

   typedef struct packed {
      int          k;
      logic [15:0] a0;
      logic [15:0] b0;
      logic [15:0] a1;
      logic [15:0] b1;
      int          gap;
      int          lat;
      logic [79:0] exp_c;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic send_beat(input logic [15:0] av, input logic [15:0] bv, input logic lst);
      int w;
      @(negedge clock);
      in_valid = 1'b1; a = av; b = bv; in_last = lst;
      w = 0;
      while (in_ready !== 1'b1 && w < 50) begin
         @(negedge clock);
         w++;
      end
      check("accept_wait", 128'(w < 50), 128'(1));
      @(posedge clock);
   endtask

   // Entered right after the accepting edge of the last beat; returns at the negedge where out_valid is seen.
   task automatic wait_result(output int lat);
      @(negedge clock);
      in_valid = 1'b0; in_last = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 50) begin
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check("post_hs_out_valid", 128'(out_valid), 128'(0));
      check("post_hs_c_cleared", 128'(c), 128'(0));
      check("post_hs_in_ready", 128'(in_ready), 128'(1));
      check("post_hs_busy", 128'(busy), 128'(0));
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      send_beat(v.a0, v.b0, v.k == 1);
      if (v.k == 2) begin
         for (int g = 0; g < v.gap; g++) begin
            @(negedge clock);
            in_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
         end
         send_beat(v.a1, v.b1, 1'b1);
      end
      wait_result(lat);
      check("latency", 128'(lat), 128'(v.lat));
      check("c_result", 128'(c), 128'(v.exp_c));
   endtask

   initial begin
      int          lat;
      logic        seen;
      logic [23:0] ta [3];
      logic [15:0] tb [3];
      logic [63:0] exp16;

      vecs[0] = '{k: 2, a0: {8'd3, 8'd1}, b0: {8'd6, 8'd5}, a1: {8'd4, 8'd2}, b1: {8'd8, 8'd7},
                  gap: 0, lat: 4, exp_c: {20'd50, 20'd43, 20'd22, 20'd19}};
      vecs[1] = '{k: 2, a0: {8'd3, 8'd1}, b0: {8'd6, 8'd5}, a1: {8'd4, 8'd2}, b1: {8'd8, 8'd7},
                  gap: 3, lat: 4, exp_c: {20'd50, 20'd43, 20'd22, 20'd19}};
      vecs[2] = '{k: 1, a0: {8'd2, 8'd2}, b0: {8'd3, 8'd3}, a1: 16'd0, b1: 16'd0,
                  gap: 0, lat: 4, exp_c: {20'd6, 20'd6, 20'd6, 20'd6}};
      vecs[3] = '{k: 1, a0: {8'd1, 8'd1}, b0: {8'd1, 8'd1}, a1: 16'd0, b1: 16'd0,
                  gap: 0, lat: 4, exp_c: {20'd1, 20'd1, 20'd1, 20'd1}};
      vecs[4] = '{k: 2, a0: {8'd0, 8'd255}, b0: {8'd2, 8'd1}, a1: {8'd10, 8'd0}, b1: {8'd4, 8'd3},
                  gap: 1, lat: 4, exp_c: {20'd40, 20'd30, 20'd510, 20'd255}};

      // reset state
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_c", 128'(c), 128'(0));
      reset = 1'b0;
      @(negedge clock);
      check("rst_release_in_ready", 128'(in_ready), 128'(1));

      // table-driven multiplies
      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i]);
         handshake();
      end

      // backpressure in DONE, with a beat offered while not ready
      send_beat(vecs[0].a0, vecs[0].b0, 1'b0);
      send_beat(vecs[0].a1, vecs[0].b1, 1'b1);
      wait_result(lat);
      check("bp_latency", 128'(lat), 128'(4));
      in_valid = 1'b1; a = {8'd2, 8'd2}; b = {8'd3, 8'd3}; in_last = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clock);
         check("bp_out_valid_held", 128'(out_valid), 128'(1));
         check("bp_c_stable", 128'(c), 128'(vecs[0].exp_c));
         check("bp_in_ready_low", 128'(in_ready), 128'(0));
         check("bp_busy", 128'(busy), 128'(1));
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check("bp_hs_in_ready", 128'(in_ready), 128'(1));
      check("bp_hs_c_clear", 128'(c), 128'(0));
      @(posedge clock);
      wait_result(lat);
      check("bp_next_latency", 128'(lat), 128'(4));
      check("bp_next_c", 128'(c), 128'(vecs[2].exp_c));
      handshake();

      // reset mid-DRAIN
      send_beat(vecs[0].a0, vecs[0].b0, 1'b0);
      send_beat(vecs[0].a1, vecs[0].b1, 1'b1);
      @(negedge clock);
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("midrst_out_valid", 128'(out_valid), 128'(0));
      check("midrst_c", 128'(c), 128'(0));
      @(negedge clock);
      check("midrst_in_ready", 128'(in_ready), 128'(1));
      check("midrst_c_after", 128'(c), 128'(0));
      seen = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clock);
         seen = seen | out_valid;
      end
      check("midrst_no_out_valid", 128'(seen), 128'(0));
      run_vec(vecs[3]);
      handshake();

      // 16-bit accumulators, two beats of 255*255
`ifdef SYSTOLIC_SATURATE_EN
      exp16 = {4{16'd65535}};
`else
      exp16 = {4{16'd64514}};
`endif
      for (int k = 0; k < 2; k++) begin
         int w;
         @(negedge clock);
         h_in_valid = 1'b1; h_a = 16'hFFFF; h_b = 16'hFFFF; h_in_last = (k == 1);
         w = 0;
         while (h_in_ready !== 1'b1 && w < 50) begin
            @(negedge clock);
            w++;
         end
         check("acc16_accept_wait", 128'(w < 50), 128'(1));
         @(posedge clock);
      end
      @(negedge clock);
      h_in_valid = 1'b0; h_in_last = 1'b0;
      lat = 0;
      while (h_out_valid !== 1'b1 && lat < 50) begin
         @(negedge clock);
         lat++;
      end
      check("acc16_latency", 128'(lat), 128'(4));
      check("acc16_c", 128'(h_c), 128'(exp16));
      h_out_ready = 1'b1;
      @(negedge clock);
      h_out_ready = 1'b0;
      check("acc16_hs_out_valid", 128'(h_out_valid), 128'(0));
      check("acc16_hs_c", 128'(h_c), 128'(0));

      // 3x2 array with unit-vector A columns: C rows equal B rows
      ta[0] = 24'h000001; ta[1] = 24'h000100; ta[2] = 24'h010000;
      tb[0] = {8'd2, 8'd1}; tb[1] = {8'd4, 8'd3}; tb[2] = {8'd6, 8'd5};
      for (int k = 0; k < 3; k++) begin
         int w;
         @(negedge clock);
         t_in_valid = 1'b1; t_a = ta[k]; t_b = tb[k]; t_in_last = (k == 2);
         w = 0;
         while (t_in_ready !== 1'b1 && w < 50) begin
            @(negedge clock);
            w++;
         end
         check("r3_accept_wait", 128'(w < 50), 128'(1));
         @(posedge clock);
      end
      @(negedge clock);
      t_in_valid = 1'b0; t_in_last = 1'b0;
      lat = 0;
      while (t_out_valid !== 1'b1 && lat < 50) begin
         @(negedge clock);
         lat++;
      end
      check("r3_latency", 128'(lat), 128'(5));
      check("r3_c", 128'(t_c), 128'({20'd6, 20'd5, 20'd4, 20'd3, 20'd2, 20'd1}));
      check("r3_busy", 128'(t_busy), 128'(1));
      t_out_ready = 1'b1;
      @(negedge clock);
      t_out_ready = 1'b0;
      check("r3_hs_out_valid", 128'(t_out_valid), 128'(0));
      check("r3_hs_in_ready", 128'(t_in_ready), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
